// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key event outputs of keypad_scanner.
interface keypad_scanner_if;
    logic [3:0] rows_i;
    logic [3:0] cols_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    modport slave (
        input  rows_i,
        output cols_o, key_code, key_valid, key_held, multi_key
    );

    modport master (
        output rows_i,
        input  cols_o, key_code, key_valid, key_held, multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column drive, per-frame debounce, one-cycle key_valid.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a single key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV      = 50000,
    parameter int STABLE_FRAMES = 4,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_RATE   = 10
) (
    input  logic            clk_50mhz,
    input  logic            rst_n,
    keypad_scanner_if.slave kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t             st_q, st_d;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         col_q;
    logic [3:0]         sync1_q, sync2_q;
    logic [15:0]        frame_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         code_q, code_d;
    logic               multi_q, multi_d;
    logic               valid_q;
    logic               accept;
    logic               fire;
    logic               tick, frame_end;
    logic [15:0]        full;
    logic [4:0]         ones;
    logic [3:0]         pos;
    logic [3:0]         s_code;
    logic               none, one;

    assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tick && (col_q == 2'd3);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            div_q   <= '0;
            col_q   <= '0;
            frame_q <= '0;
        end else begin
            sync1_q <= kp.rows_i;
            sync2_q <= sync1_q;
            div_q   <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                frame_q[col_q*4 +: 4] <= ~sync2_q;
                col_q                 <= col_q + 2'd1;
            end
        end
    end

    // Frame is column-major (bit = col*4+row); key codes are row-major.
    always_comb begin
        full = {~sync2_q, frame_q[11:0]};
        ones = '0;
        pos  = '0;
        for (int i = 0; i < 16; i++) begin
            ones = ones + 5'(full[i]);
            if (full[i]) pos = 4'(i);
        end
        s_code = {pos[1:0], pos[3:2]};
        none   = (ones == 5'd0);
        one    = (ones == 5'd1);
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        multi_d = multi_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (st_q)
                IDLE: begin
                    if (one) begin
                        cand_d = s_code;
                        if (STABLE_FRAMES == 1) begin
                            code_d = s_code;
                            accept = 1'b1;
                            st_d   = PRESSED;
                        end else begin
                            cnt_d = CNT_W'(1);
                            st_d  = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (one && s_code == cand_q) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(STABLE_FRAMES)) begin
                            code_d = cand_q;
                            accept = 1'b1;
                            cnt_d  = '0;
                            st_d   = PRESSED;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                        st_d  = IDLE;
                    end
                end
                PRESSED: begin
                    if (none) begin
                        if (STABLE_FRAMES == 1) begin
                            multi_d = 1'b0;
                            st_d    = IDLE;
                        end else begin
                            cnt_d = CNT_W'(1);
                            st_d  = RELEASE;
                        end
                    end else if (one) begin
                        multi_d = 1'b0;
                    end else begin
                        multi_d = 1'b1;
                    end
                end
                RELEASE: begin
                    if (none) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(STABLE_FRAMES)) begin
                            cnt_d   = '0;
                            multi_d = 1'b0;
                            st_d    = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                        st_d  = PRESSED;
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_run_q, rep_run_d;
    logic             rep_pulse;

    // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE frames.
    always_comb begin
        rep_d     = rep_q;
        rep_run_d = rep_run_q;
        rep_pulse = 1'b0;
        if (frame_end) begin
            if (st_q == PRESSED && one && s_code == code_q) begin
                if (rep_q + REP_W'(1) == (rep_run_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
                    rep_pulse = 1'b1;
                    rep_d     = '0;
                    rep_run_d = 1'b1;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end else begin
                rep_d     = '0;
                rep_run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            rep_q     <= '0;
            rep_run_q <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            rep_run_q <= rep_run_d;
        end
    end

    assign fire = accept | rep_pulse;
`else
    assign fire = accept;
`endif

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            valid_q <= fire;
        end
    end

    assign kp.cols_o    = ~(4'b0001 << col_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = (st_q == PRESSED) || (st_q == RELEASE);
    assign kp.multi_key = multi_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench for keypad_scanner: directed vector table, reset/repeat sequences, random keys vs model.
module tb_keypad_scanner;
    localparam int SD = 4, SF = 3, RD = 4, RR = 2;
    localparam int FRAME = 4 * SD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] keys  = '0;
    logic [3:0]  rows;

    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SD), .STABLE_FRAMES(SF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk_50mhz(clk),
        .rst_n(rst_n),
        .kp(kp)
    );

    // Membrane model: a pressed key (code row*4+col) pulls its row low when its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) rows[r] = ~|(keys[r*4 +: 4] & ~kp.cols_o);
    end
    assign kp.rows_i = rows;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Applies a key set for one full frame; returns after the frame-end result is visible.
    task automatic run_frame(input logic [15:0] k, output int pulses);
        keys   = k;
        pulses = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (kp.key_valid) pulses++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: tracks run lengths of identical frames.
    logic m_held, m_multi;
    int   m_code, m_run, m_last, m_erun, m_rep;
    logic m_rrun;

    task automatic model_reset();
        m_held = 0; m_multi = 0; m_code = 0; m_run = 0; m_last = 0;
        m_erun = 0; m_rep = 0; m_rrun = 0;
    endtask

    task automatic model_frame(input logic [15:0] k, output int p);
        int n, s;
        n = $countones(k);
        s = 0;
        for (int i = 0; i < 16; i++) if (k[i]) s = i;
        p = 0;
        if (!m_held) begin
            if (n != 1 || (m_run > 0 && s != m_last)) m_run = 0;
            else begin
                m_last = s;
                m_run++;
                if (m_run == SF) begin
                    p = 1; m_held = 1; m_code = s; m_run = 0; m_erun = 0;
                    m_rep = 0; m_rrun = 0;
                end
            end
        end else if (m_erun == 0) begin
            if (n == 0) m_erun = 1;
            else m_multi = (n > 1);
`ifdef KEYPAD_REPEAT_EN
            if (n == 1 && s == m_code) begin
                m_rep++;
                if (m_rep == (m_rrun ? RR : RD)) begin p = 1; m_rep = 0; m_rrun = 1; end
            end else begin
                m_rep = 0; m_rrun = 0;
            end
`endif
        end else begin
            if (n == 0) begin
                m_erun++;
                if (m_erun == SF) begin m_held = 0; m_multi = 0; m_erun = 0; end
            end else m_erun = 0;
            m_rep = 0; m_rrun = 0;
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          v;
        int          code;
        logic        held;
        logic        multi;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] k, input int v, input int code, input logic held, input logic multi);
        vec_t e;
        e.keys = k; e.v = v; e.code = code; e.held = held; e.multi = multi;
        tbl.push_back(e);
    endtask

    localparam logic [15:0] K0 = 16'h0001, K3 = 16'h0008, K5 = 16'h0020, K6 = 16'h0040;
    localparam logic [15:0] K9 = 16'h0200, K12 = 16'h1000, K15 = 16'h8000, KN = 16'h0000;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int p, cur;

        // Hold code 9 six frames, release
        add(K9, 0, 0, 0, 0); add(K9, 0, 0, 0, 0); add(K9, 1, 9, 1, 0);
        add(K9, 0, 9, 1, 0); add(K9, 0, 9, 1, 0); add(K9, 0, 9, 1, 0);
        add(KN, 0, 9, 1, 0); add(KN, 0, 9, 1, 0); add(KN, 0, 9, 0, 0);
        // One-frame tap of code 3, then a clean press of 9 from IDLE
        add(K3, 0, 9, 0, 0); add(KN, 0, 9, 0, 0);
        add(K9, 0, 9, 0, 0); add(K9, 0, 9, 0, 0); add(K9, 1, 9, 1, 0);
        add(KN, 0, 9, 1, 0); add(KN, 0, 9, 1, 0); add(KN, 0, 9, 0, 0);
        // Ghosting from IDLE, then multi-key while pressed
        add(K0 | K5, 0, 9, 0, 0); add(K0 | K5, 0, 9, 0, 0); add(K0 | K5, 0, 9, 0, 0);
        add(K9, 0, 9, 0, 0); add(K9, 0, 9, 0, 0); add(K9, 1, 9, 1, 0);
        add(K9 | K0, 0, 9, 1, 1); add(K9 | K0, 0, 9, 1, 1);
        add(K9, 0, 9, 1, 0); add(K6, 0, 9, 1, 0);
        add(KN, 0, 9, 1, 0); add(KN, 0, 9, 1, 0); add(KN, 0, 9, 0, 0);
        // Code 12 with a bounce during release
        add(K12, 0, 9, 0, 0); add(K12, 0, 9, 0, 0); add(K12, 1, 12, 1, 0);
        add(KN, 0, 12, 1, 0); add(K12, 0, 12, 1, 0);
        add(KN, 0, 12, 1, 0); add(KN, 0, 12, 1, 0); add(KN, 0, 12, 0, 0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cols", kp.cols_o, 4'b1110);
        chk("rst_code", kp.key_code, 0);
        chk("rst_valid", kp.key_valid, 0);
        chk("rst_held", kp.key_held, 0);
        chk("rst_multi", kp.multi_key, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_frame(tbl[i].keys, p);
            chk($sformatf("tbl%0d_pulse", i), p, tbl[i].v);
            chk($sformatf("tbl%0d_code", i), kp.key_code, tbl[i].code);
            chk($sformatf("tbl%0d_held", i), kp.key_held, tbl[i].held);
            chk($sformatf("tbl%0d_multi", i), kp.multi_key, tbl[i].multi);
            chk($sformatf("tbl%0d_cols", i), kp.cols_o, 4'b1110);
        end

        // Reset while code 9 is held, key stays down
        for (int f = 1; f <= 4; f++) begin
            run_frame(K9, p);
            chk($sformatf("pre_rst_f%0d_pulse", f), p, (f == 3) ? 1 : 0);
        end
        chk("pre_rst_held", kp.key_held, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_held", kp.key_held, 0);
        chk("mid_rst_code", kp.key_code, 0);
        chk("mid_rst_valid", kp.key_valid, 0);
        chk("mid_rst_multi", kp.multi_key, 0);
        chk("mid_rst_cols", kp.cols_o, 4'b1110);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            run_frame(K9, p);
            chk($sformatf("post_rst_f%0d_pulse", f), p, (f == 3) ? 1 : 0);
            chk($sformatf("post_rst_f%0d_held", f), kp.key_held, (f == 3) ? 1 : 0);
        end
        chk("post_rst_code", kp.key_code, 9);

`ifdef KEYPAD_REPEAT_EN
        do_reset();
        for (int f = 1; f <= 12; f++) begin
            run_frame(K15, p);
            chk($sformatf("rep_f%0d_pulse", f), p, (f == 3 || f == 7 || f == 9 || f == 11) ? 1 : 0);
        end
        chk("rep_code", kp.key_code, 15);
        for (int f = 1; f <= 3; f++) run_frame(KN, p);
        chk("rep_release_held", kp.key_held, 0);
`endif

        // Random key sequences against the model
        do_reset();
        model_reset();
        cur = 9;
        for (int f = 0; f < 90; f++) begin
            logic [15:0] k;
            int r, a, b, ep;
            r = $urandom_range(0, 11);
            if (r < 2)       k = '0;
            else if (r < 8)  k = 16'(1) << cur;
            else if (r == 8) begin cur = $urandom_range(0, 15); k = 16'(1) << cur; end
            else if (r == 9) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                if (a == b) b = (a + 1) % 16;
                k = (16'(1) << a) | (16'(1) << b);
            end else begin
                a = $urandom_range(0, 15);
                if (a == cur) a = (a + 3) % 16;
                k = (16'(1) << cur) | (16'(1) << a);
            end
            run_frame(k, p);
            model_frame(k, ep);
            chk($sformatf("rnd%0d_pulse", f), p, ep);
            chk($sformatf("rnd%0d_code", f), kp.key_code, m_code);
            chk($sformatf("rnd%0d_held", f), kp.key_held, m_held);
            chk($sformatf("rnd%0d_multi", f), kp.multi_key, m_multi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
